// File: rtl/team_06_audio_pkg.sv
// Shared types and helpers for the team_06 audio effects chain.
// The soft-clip curve lives here so every stage agrees on its shape.
package team_06_audio_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'b00,
        SOFT   = 2'b01,
        HARD   = 2'b10
    } mode_t;

    localparam int MID = 128;

    // Knee-compressed deviation: slope 1/2**shift above the knee, capped at max_dev.
    function automatic logic [31:0] soft_dev(
        input logic [31:0] d,
        input logic [31:0] knee,
        input int unsigned shift,
        input logic [31:0] max_dev
    );
        logic [31:0] t;
        t = knee + ((d - knee) >> shift);
        if (d <= knee) return d;
        return (t > max_dev) ? max_dev : t;
    endfunction

endpackage

// File: rtl/team_06_clip_hold.sv
// One channel's clip-indicator hold counter.
// A load restarts the full hold time; the LED is on while the count is nonzero.
module team_06_clip_hold #(
    parameter int HOLD = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic led_o
);

    localparam int CNTW = $clog2(HOLD + 1);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNTW'(HOLD);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign led_o = (cnt_q != '0);

endmodule

// File: rtl/team_06_soft_clip_pipe.sv
// Two-stage soft clipper on an offset-binary valid/ready sample stream.
// S1 folds the sample to sign/deviation; S2 shapes the deviation and rebuilds it.
module team_06_soft_clip_pipe
    import team_06_audio_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NCH      = 2,
    parameter int SHIFT    = 2,
    parameter int MAX_DEV  = 60,
    parameter int KNEE_RST = 40,
    parameter int HOLD     = 1024,
    parameter int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             cfg_we,
    input  logic [WIDTH-2:0] knee_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sample,
    input  logic [CW-1:0]    in_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sample,
    output logic [CW-1:0]    out_ch,
    output logic [NCH-1:0]   clip_led
);

    localparam int MIDV = 1 << (WIDTH - 1);

    logic [WIDTH-2:0] knee_q;
    logic [WIDTH-2:0] knee_d;

    logic             s1_valid_q;
    logic             s1_sign_q;
    logic [WIDTH-1:0] s1_d_q;
    logic [CW-1:0]    s1_ch_q;
    logic [1:0]       s1_mode_q;
    logic [WIDTH-2:0] s1_knee_q;

    logic             s1_sign_d;
    logic [WIDTH-1:0] s1_d_d;
    logic [WIDTH:0]   x_x;
    logic [WIDTH:0]   mid_x;
    logic [WIDTH:0]   diff;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_out_q;
    logic [CW-1:0]    s2_ch_q;
    logic             s2_clip_q;

    logic [31:0]      e32;
    logic [WIDTH-1:0] e_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] s2_out_d;
    logic             s2_clip_d;

    logic             adv;
    logic             xfer;
    logic             unused_bits;

    // The whole pipe moves together; a stalled output freezes both stages.
    assign adv      = !s2_valid_q || out_ready;
    assign in_ready = adv;
    assign xfer     = s2_valid_q && out_ready;

    assign knee_d = (32'(knee_in) > 32'(MAX_DEV))
                  ? (WIDTH-1)'(MAX_DEV) : knee_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            knee_q <= (WIDTH-1)'(KNEE_RST);
        end else if (cfg_we) begin
            knee_q <= knee_d;
        end
    end

    assign x_x       = {1'b0, in_sample};
    assign mid_x     = (WIDTH+1)'(MIDV);
    assign s1_sign_d = (in_sample >= WIDTH'(MIDV));
    assign diff      = s1_sign_d ? (x_x - mid_x) : (mid_x - x_x);
    assign s1_d_d    = diff[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_d_q     <= '0;
            s1_ch_q    <= '0;
            s1_mode_q  <= '0;
            s1_knee_q  <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_d_q    <= s1_d_d;
                s1_ch_q   <= in_ch;
                s1_mode_q <= mode;
                s1_knee_q <= knee_q;
            end
        end
    end

    always_comb begin
        e32 = 32'(s1_d_q);
        case (s1_mode_q)
            SOFT: e32 = soft_dev(32'(s1_d_q), 32'(s1_knee_q),
                                 SHIFT, 32'(MAX_DEV));
            HARD: e32 = (32'(s1_d_q) < 32'(s1_knee_q))
                      ? 32'(s1_d_q) : 32'(s1_knee_q);
            default: e32 = 32'(s1_d_q);
        endcase
    end

    assign e_d       = e32[WIDTH-1:0];
    assign sum       = s1_sign_q ? (mid_x + {1'b0, e_d})
                                 : (mid_x - {1'b0, e_d});
    assign s2_out_d  = sum[WIDTH-1:0];
    assign s2_clip_d = (e_d != s1_d_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_out_q   <= WIDTH'(MIDV);
            s2_ch_q    <= '0;
            s2_clip_q  <= 1'b0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_out_q  <= s2_out_d;
                s2_ch_q   <= s1_ch_q;
                s2_clip_q <= s2_clip_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_sample = s2_out_q;
    assign out_ch     = s2_ch_q;

    // Tags outside 0..NCH-1 match no counter, so their clips never light a LED.
    for (genvar g = 0; g < NCH; g++) begin : g_hold
        team_06_clip_hold #(
            .HOLD (HOLD)
        ) u_hold (
            .clk    (clk),
            .rst    (rst),
            .load_i (xfer && s2_clip_q && (s2_ch_q == CW'(g))),
            .led_o  (clip_led[g])
        );
    end

    assign unused_bits = ^{diff[WIDTH], sum[WIDTH], e32[31:WIDTH]};

endmodule

// File: tb/tb_team_06_soft_clip_pipe.sv
// Directed and randomized checks of team_06_soft_clip_pipe against
// an arithmetic reference model with a scoreboard queue and LED timers.
module tb_team_06_soft_clip_pipe;

    localparam int HOLD = 1024;
    localparam int KRST = 40;
    localparam int MAXD = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       cfg_we = 1'b0;
    logic [6:0] knee_in = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_sample = '0;
    logic [0:0] in_ch = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_sample;
    logic [0:0] out_ch;
    logic [1:0] clip_led;

    team_06_soft_clip_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .cfg_we     (cfg_we),
        .knee_in    (knee_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .in_ch      (in_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_ch     (out_ch),
        .clip_led   (clip_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int out;
        int ch;
        bit clip;
    } exp_t;

    exp_t q[$];
    int   knee_m = KRST;
    int   cnt_m[2];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int x, input int m,
                                   input int ch, input int k);
        exp_t r;
        int d, e, over;
        d = (x >= 128) ? x - 128 : 128 - x;
        e = d;
        if (m == 1 && d > k) begin
            over = k + (d - k) / 4;
            e = (over > MAXD) ? MAXD : over;
        end else if (m == 2 && d > k) begin
            e = k;
        end
        r.out  = (x >= 128) ? 128 + e : 128 - e;
        r.ch   = ch;
        r.clip = (e != d);
        return r;
    endfunction

    task automatic tick(output bit acc);
        bit   xf;
        exp_t h;
        #1;
        acc = in_valid && in_ready;
        xf  = out_valid && out_ready;
        h   = '{out: 0, ch: 0, clip: 1'b0};
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                h = q[0];
                chk("out_sample", 32'(out_sample), 32'(h.out));
                chk("out_ch", 32'(out_ch), 32'(h.ch));
                if (xf) void'(q.pop_front());
            end
        end
        if (acc) begin
            q.push_back(model(int'(in_sample), int'(mode),
                              int'(in_ch), knee_m));
        end
        @(posedge clk);
        for (int c = 0; c < 2; c++) if (cnt_m[c] > 0) cnt_m[c]--;
        if (xf && h.clip && h.ch < 2) cnt_m[h.ch] = HOLD;
        if (cfg_we) knee_m = (int'(knee_in) > MAXD) ? MAXD : int'(knee_in);
        @(negedge clk);
        chk("clip_led", 32'(clip_led),
            32'({cnt_m[1] != 0, cnt_m[0] != 0}));
    endtask

    task automatic send(input int x, input int ch, input int m);
        bit acc;
        acc = 1'b0;
        in_valid  = 1'b1;
        in_sample = 8'(x);
        in_ch     = 1'(ch);
        mode      = 2'(m);
        for (int i = 0; i < 50 && !acc; i++) tick(acc);
        chk("send_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick(acc);
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    initial begin
        bit       acc;
        int       idx;
        int       sv[3];
        bit       have;
        cnt_m[0] = 0;
        cnt_m[1] = 0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sample", 32'(out_sample), 32'd128);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_clip_led", 32'(clip_led), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // soft mode, ch0, with latency check on the first sample
        send(128, 0, 1);
        chk("lat_1cyc_idle", 32'(out_valid), 32'd0);
        send(200, 0, 1);
        chk("lat_2cyc_valid", 32'(out_valid), 32'd1);
        send(20, 0, 1);
        send(255, 0, 1);
        send(0, 0, 1);
        drain();

        send(200, 0, 2);
        send(60, 0, 2);
        send(255, 1, 0);
        drain();

        // stall: 3 samples offered while the output is blocked
        sv[0] = 210;
        sv[1] = 30;
        sv[2] = 140;
        idx = 0;
        out_ready = 1'b0;
        mode = 2'd1;
        in_ch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid  = (idx < 3);
            in_sample = 8'((idx < 3) ? sv[idx] : 0);
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'(i < 2));
            tick(acc);
            if (acc) idx++;
        end
        chk("stall_accepts", 32'(idx), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (idx < 3 || q.size() > 0); i++) begin
            in_valid  = (idx < 3);
            in_sample = 8'((idx < 3) ? sv[idx] : 0);
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("stall_all_in", 32'(idx), 32'd3);
        drain();

        // knee write on the same edge as an accept uses the old knee
        cfg_we  = 1'b1;
        knee_in = 7'd20;
        send(200, 0, 1);
        cfg_we = 1'b0;
        send(200, 0, 1);
        cfg_we  = 1'b1;
        knee_in = 7'd100;
        idle(1);
        cfg_we = 1'b0;
        send(200, 0, 1);
        send(200, 1, 2);
        drain();

        // randomized traffic
        have = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!have) begin
                in_sample = 8'($urandom_range(255));
                in_ch     = 1'($urandom_range(1));
                mode      = 2'($urandom_range(3));
                have      = ($urandom_range(3) != 0);
            end
            in_valid  = have;
            out_ready = ($urandom_range(3) != 0);
            cfg_we    = ($urandom_range(9) == 0);
            knee_in   = 7'($urandom_range(127));
            tick(acc);
            if (acc) have = 1'b0;
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        drain();

        // reset with two samples in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sample = 8'd250;
        in_ch     = 1'b0;
        mode      = 2'd2;
        tick(acc);
        in_sample = 8'd5;
        tick(acc);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_fly_valid", 32'(out_valid), 32'd0);
        chk("rst_fly_led", 32'(clip_led), 32'd0);
        chk("rst_fly_sample", 32'(out_sample), 32'd128);
        q.delete();
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        knee_m = KRST;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // ch1 clip hold and re-clip extension
        send(255, 1, 1);
        drain();
        chk("led_ch1_only", 32'(clip_led), 32'd2);
        idle(495);
        send(0, 1, 2);
        idle(1100);
        chk("led_expired", 32'(clip_led), 32'd0);

        // knee back at its reset value after the mid-flight reset
        send(200, 0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
